// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: assembles LSB-first N-bit words framed by
// sync_in, queues completed words in a small FIFO, and reports framing
// errors and overruns through one-cycle pulses and a saturating counter.
//
// Handshake: the head word is offered on data_out while data_valid is high.
// It is consumed on any rising edge where data_valid && data_ready. data_out
// is stable while data_valid && !data_ready, and reads 0 when the buffer is
// empty.
module serial_to_parallel_rx #(
  parameter int N     = 14,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_in,
  input  logic         sync_in,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         frame_err,
  output logic         overrun,
  output logic [7:0]   err_cnt,
  output logic         dbg_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = AW + 1;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    sr_q, sr_d;
  logic [N-1:0]    mem_q [DEPTH];
  logic [N-1:0]    mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   count_q, count_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic            push;
  logic [N-1:0]    push_word;
  logic            pop;
  logic            full;
  logic            push_ok;
  logic [8:0]      err_sum;

  // Framing FSM: hunts for the first sync, then shifts bits into the word
  // and raises push on the cycle bit N-1 arrives.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    push        = 1'b0;
    push_word   = sr_q;
    frame_err_d = 1'b0;
    case (state_q)
      HUNT: begin
        if (sync_in) begin
          sr_d    = '0;
          sr_d[0] = serial_in;
          cnt_d   = CW'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (sync_in && (cnt_q != '0)) begin
          // Early sync: partial word is abandoned, new word starts here.
          frame_err_d = 1'b1;
          sr_d        = '0;
          sr_d[0]     = serial_in;
          cnt_d       = CW'(1);
        end else begin
          if (cnt_q == '0) begin
            sr_d = '0;
          end
          sr_d[cnt_q] = serial_in;
          if (cnt_q == CW'(N - 1)) begin
            push      = 1'b1;
            push_word = sr_d;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = HUNT;
        cnt_d   = '0;
      end
    endcase
  end

  // Output FIFO bookkeeping: a push while full is kept only if the head is
  // popped on the same edge; otherwise the new word is dropped as an overrun.
  always_comb begin
    pop      = (count_q != '0) && data_ready;
    full     = (count_q == OW'(DEPTH));
    push_ok  = push && (!full || pop);
    overrun_d = push && full && !pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + OW'(push_ok) - OW'(pop);
  end

  // Error counter: both event sources may fire together, so add up to 2
  // and clamp at 255.
  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + 9'(frame_err_d) + 9'(overrun_d);
    err_cnt_d = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      sr_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign data_valid = (count_q != '0);
  assign data_out   = data_valid ? mem_q[rd_ptr_q] : '0;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign err_cnt    = err_cnt_q;
  assign dbg_state  = (state_q == RECV);

endmodule
